// File: rtl/axis_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : axis_trigger_capture
// Description : Trigger-gated AXI-Stream window. A rising edge on trigger_in
//               opens a window of CAPTURE_LEN beats. The window connects the
//               slave stream straight to the master stream with no buffering
//               and no added latency. Outside a window, upstream samples are
//               accepted and dropped.
//
// Parameters  : DATA_W       sample bus width in bits
//               CAPTURE_LEN  beats forwarded per trigger (1 .. 65536)
//
// Ports       : aclk           single clock, rising edge
//               aresetn        synchronous, active-low reset
//               trigger_in     periodic trigger pulse, any width
//               s_axis_*       upstream stream (tdata / tvalid / tready)
//               m_axis_*       downstream stream (tdata / tvalid / tready / tlast)
//               busy           high while a capture window is open
//               overrun        sticky: a trigger edge arrived during a window
//               trig_period    (optional) cycles between the last two edges
//               trig_count     (optional) number of detected edges, wrapping
//
// Options     : define TRIG_PERIOD_MON_EN to add trig_period / trig_count.
//
// Revision    : 1.0 - initial release
// ============================================================================
module axis_trigger_capture #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned CAPTURE_LEN = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              trigger_in,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              overrun
`ifdef TRIG_PERIOD_MON_EN
    ,
    output logic [31:0]       trig_period,
    output logic [31:0]       trig_count
`endif
);

    // One spare bit over the minimum so CAPTURE_LEN = 2^n still fits its
    // last index comfortably and CAPTURE_LEN = 1 yields a 1-bit counter.
    localparam int unsigned        c_CNT_W     = $clog2(CAPTURE_LEN) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(CAPTURE_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [c_CNT_W-1:0] beat_cnt_q;
    logic [c_CNT_W-1:0] beat_cnt_d;
    logic               overrun_q;
    logic               overrun_d;
    // Previous-cycle copy of trigger_in, used for edge detection.
    logic               trig_prev_q;

    logic               trig_rise;
    logic               m_hs;
    logic               last_beat;

    // A held-high trigger produces one edge only; cleared on reset so that
    // a trigger already high when reset releases counts as a new edge.
    assign trig_rise = trigger_in & ~trig_prev_q;
    assign overrun   = overrun_q;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            overrun_q   <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            overrun_q   <= overrun_d;
            trig_prev_q <= trigger_in;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        overrun_d     = overrun_q;
        s_axis_tready = 1'b1;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        busy          = 1'b0;
        m_hs          = 1'b0;
        last_beat     = (beat_cnt_q == c_LAST_BEAT);

        unique case (state_q)
            ST_IDLE: begin
                // Upstream is drained while idle so it never backs up.
                if (trig_rise) begin
                    state_d    = ST_CAPTURE;
                    beat_cnt_d = '0;
                end
            end

            ST_CAPTURE: begin
                busy          = 1'b1;
                // Pure wire-through: every AXI-Stream stability guarantee on
                // the master side is inherited from the upstream source.
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = last_beat;
                m_hs          = s_axis_tvalid & m_axis_tready;

                // Edges during a window (including the tlast cycle) are lost.
                if (trig_rise) begin
                    overrun_d = 1'b1;
                end

                if (m_hs) begin
                    if (last_beat) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + c_CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

`ifdef TRIG_PERIOD_MON_EN
    // ------------------------------------------------------------------------
    // Trigger period / count monitor
    // ------------------------------------------------------------------------
    logic [31:0] elapsed_q;
    logic [31:0] period_q;
    logic [31:0] count_q;
    logic        seen_edge_q;

    // elapsed_q holds the number of cycles since the most recent edge, so on
    // the next edge it is exactly the edge-to-edge distance. It saturates so
    // a very long gap reports all-ones instead of wrapping.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            elapsed_q   <= '0;
            period_q    <= '0;
            count_q     <= '0;
            seen_edge_q <= 1'b0;
        end else if (trig_rise) begin
            elapsed_q   <= 32'd1;
            count_q     <= count_q + 32'd1;
            seen_edge_q <= 1'b1;
            if (seen_edge_q) begin
                period_q <= elapsed_q;
            end
        end else if (elapsed_q != 32'hFFFF_FFFF) begin
            elapsed_q <= elapsed_q + 32'd1;
        end
    end

    assign trig_period = period_q;
    assign trig_count  = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_trigger_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axis_trigger_capture
// Description : Scoreboard bench for axis_trigger_capture. Two instances are
//               driven side by side, one with an 8-beat window and one with a
//               1-beat window, from a shared trigger and reset. A window-level
//               reference model predicts per-cycle status and every forwarded
//               beat; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_trigger_capture;

    localparam int DW = 32;

    typedef struct packed {
        logic [4:0]  st;   // busy, overrun, s_tready, m_tvalid, m_tlast
        logic [31:0] per;
        logic [31:0] cnt;
    } stat_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    logic          aclk;
    logic          aresetn;
    logic          trigger_in;
    logic [DW-1:0] s_tdata [2];
    logic [DW-1:0] m_tdata [2];
    logic [1:0]    s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, busy, overrun;
`ifdef TRIG_PERIOD_MON_EN
    logic [31:0]   trig_period [2];
    logic [31:0]   trig_count  [2];
`endif

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    axis_trigger_capture #(.DATA_W(DW), .CAPTURE_LEN(8)) u_dut8 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .trigger_in    (trigger_in),
        .s_axis_tdata  (s_tdata[0]),
        .s_axis_tvalid (s_tvalid[0]),
        .s_axis_tready (s_tready[0]),
        .m_axis_tdata  (m_tdata[0]),
        .m_axis_tvalid (m_tvalid[0]),
        .m_axis_tready (m_tready[0]),
        .m_axis_tlast  (m_tlast[0]),
        .busy          (busy[0]),
        .overrun       (overrun[0])
`ifdef TRIG_PERIOD_MON_EN
        ,
        .trig_period   (trig_period[0]),
        .trig_count    (trig_count[0])
`endif
    );

    axis_trigger_capture #(.DATA_W(DW), .CAPTURE_LEN(1)) u_dut1 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .trigger_in    (trigger_in),
        .s_axis_tdata  (s_tdata[1]),
        .s_axis_tvalid (s_tvalid[1]),
        .s_axis_tready (s_tready[1]),
        .m_axis_tdata  (m_tdata[1]),
        .m_axis_tvalid (m_tvalid[1]),
        .m_axis_tready (m_tready[1]),
        .m_axis_tlast  (m_tlast[1]),
        .busy          (busy[1]),
        .overrun       (overrun[1])
`ifdef TRIG_PERIOD_MON_EN
        ,
        .trig_period   (trig_period[1]),
        .trig_count    (trig_count[1])
`endif
    );

    // ------------------------------------------------------------------------
    // Scoreboard queues and counters
    // ------------------------------------------------------------------------
    stat_t sq0[$], sq1[$];
    beat_t dq0[$], dq1[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input int k,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %0h expected %0h", name, k, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a window is "remaining beats" plus an open flag.
    // ------------------------------------------------------------------------
    bit          w_open [2];
    int          w_left [2];
    bit          t_prev [2];
    bit          lost   [2];
    int          n_edge [2];
    longint      last_edge [2];
    logic [31:0] e_per  [2];
    logic [31:0] e_cnt  [2];
    bit          pend   [2];
    longint      cyc = 0;

    function automatic int win_len(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    task automatic model_step(input int k, input logic rst_n, input logic trig,
                              input logic sv, input logic mr,
                              input logic [DW-1:0] sd, output logic srdy);
        stat_t  s;
        beat_t  b;
        logic   rise;
        logic   fwd;
        longint gap;
        rise  = trig && !t_prev[k];
        srdy  = w_open[k] ? mr : 1'b1;
        fwd   = w_open[k] && sv && mr;
        s.st  = {w_open[k], lost[k], srdy, w_open[k] && sv,
                 w_open[k] && (w_left[k] == 1)};
        s.per = e_per[k];
        s.cnt = e_cnt[k];
        if (k == 0) sq0.push_back(s); else sq1.push_back(s);
        if (fwd) begin
            b.d    = sd;
            b.last = (w_left[k] == 1);
            if (k == 0) dq0.push_back(b); else dq1.push_back(b);
        end
        if (!rst_n) begin
            w_open[k] = 0; w_left[k] = 0; t_prev[k] = 0; lost[k] = 0;
            n_edge[k] = 0; e_per[k] = '0; e_cnt[k] = '0;
        end else begin
            if (rise) begin
                if (n_edge[k] > 0) begin
                    gap = cyc - last_edge[k];
                    e_per[k] = (gap > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : gap[31:0];
                end
                last_edge[k] = cyc;
                n_edge[k]++;
                e_cnt[k] = e_cnt[k] + 32'd1;
            end
            if (w_open[k]) begin
                if (rise) lost[k] = 1;
                if (fwd) begin
                    w_left[k]--;
                    if (w_left[k] == 0) w_open[k] = 0;
                end
            end else if (rise) begin
                w_open[k] = 1;
                w_left[k] = win_len(k);
            end
            t_prev[k] = trig;
        end
    endtask

    // vmode: 0 idle, 1 always valid, 2 random valid
    // rmode: 0 never ready, 1 always ready, 2 random, 3 toggle
    task automatic cycle(input logic rst_n, input logic trig,
                         input int vmode, input int rmode);
        logic srdy;
        for (int k = 0; k < 2; k++) begin
            // A beat offered but not taken stays put (AXI-Stream source rule).
            if (!pend[k]) begin
                s_tvalid[k] = (vmode == 1) ? 1'b1 :
                              (vmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
                s_tdata[k]  = $urandom;
            end
            case (rmode)
                0:       m_tready[k] = 1'b0;
                1:       m_tready[k] = 1'b1;
                2:       m_tready[k] = ($urandom_range(0, 2) != 0);
                default: m_tready[k] = ~m_tready[k];
            endcase
            model_step(k, rst_n, trig, s_tvalid[k], m_tready[k], s_tdata[k], srdy);
            pend[k] = rst_n && s_tvalid[k] && !srdy;
        end
        aresetn    = rst_n;
        trigger_in = trig;
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    task automatic mon(input int k);
        stat_t e;
        beat_t b;
        if ((k == 0 && sq0.size() == 0) || (k == 1 && sq1.size() == 0)) return;
        e = (k == 0) ? sq0.pop_front() : sq1.pop_front();
        check("status busy/ovr/srdy/mvld/mlast", k,
              {59'd0, busy[k], overrun[k], s_tready[k], m_tvalid[k], m_tlast[k]},
              {59'd0, e.st});
`ifdef TRIG_PERIOD_MON_EN
        check("trig_period", k, {32'd0, trig_period[k]}, {32'd0, e.per});
        check("trig_count",  k, {32'd0, trig_count[k]},  {32'd0, e.cnt});
`endif
        if (m_tvalid[k] && m_tready[k]) begin
            if ((k == 0 && dq0.size() == 0) || (k == 1 && dq1.size() == 0)) begin
                check("unexpected beat", k, 64'd1, 64'd0);
            end else begin
                b = (k == 0) ? dq0.pop_front() : dq1.pop_front();
                check("beat data", k, {32'd0, m_tdata[k]}, {32'd0, b.d});
                check("beat last", k, {63'd0, m_tlast[k]}, {63'd0, b.last});
            end
        end
    endtask

    always @(negedge aclk) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        aresetn    = 1'b0;
        trigger_in = 1'b0;
        s_tvalid   = '0;
        m_tready   = '0;
        s_tdata[0] = '0;
        s_tdata[1] = '0;
        for (int k = 0; k < 2; k++) begin
            w_open[k] = 0; w_left[k] = 0; t_prev[k] = 0; lost[k] = 0;
            n_edge[k] = 0; last_edge[k] = 0; e_per[k] = '0; e_cnt[k] = '0;
            pend[k] = 0;
        end
        repeat (3) @(posedge aclk);
        #1;

        // Single 1-cycle trigger, free-flowing stream.
        cycle(1, 1, 1, 1);
        repeat (12) cycle(1, 0, 1, 1);

        // Downstream ready toggling during the window.
        cycle(1, 1, 1, 3);
        repeat (20) cycle(1, 0, 1, 3);

        // Second trigger 4 cycles after the first.
        cycle(1, 1, 1, 1);
        repeat (3) cycle(1, 0, 1, 1);
        cycle(1, 1, 1, 1);
        repeat (12) cycle(1, 0, 1, 1);

        // Trigger held high for 20 cycles.
        repeat (20) cycle(1, 1, 1, 1);
        repeat (12) cycle(1, 0, 1, 1);

        // Reset with trigger high, edge right after release, then reset
        // after the third beat of the window.
        cycle(0, 1, 0, 1);
        cycle(1, 1, 1, 1);
        repeat (3) cycle(1, 0, 1, 1);
        cycle(0, 0, 0, 1);
        repeat (4) cycle(1, 0, 1, 1);

        // Randomized traffic with occasional resets.
        repeat (3000) cycle($urandom_range(0, 199) != 0, $urandom_range(0, 11) == 0, 2, 2);

`ifdef TRIG_PERIOD_MON_EN
        // Triggers every 4096 cycles.
        cycle(0, 0, 0, 1);
        for (int e = 0; e < 3; e++) begin
            cycle(1, 1, 1, 1);
            repeat (4095) cycle(1, 0, 1, 1);
        end
        check("period after 3 edges", 0, {32'd0, trig_period[0]}, 64'd4096);
        check("count after 3 edges",  0, {32'd0, trig_count[0]},  64'd3);
`endif

        repeat (4) cycle(1, 0, 0, 1);

        check("status queue drained", 0, 64'(sq0.size()), 64'd0);
        check("status queue drained", 1, 64'(sq1.size()), 64'd0);
        check("beat queue drained",   0, 64'(dq0.size()), 64'd0);
        check("beat queue drained",   1, 64'(dq1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
